// File: rtl/data_memory_16x4.sv
// Single-port 16x4 synchronous data RAM with registered read and write-through.
// Contents and read register power up cleared; synchronous reset clears everything.
module data_memory_16x4 #(
  parameter int DATA_WIDTH = 4,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  wren,
  output logic [DATA_WIDTH-1:0] q
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  // Declaration initialisers give the empty-at-power-up contents.
  logic [DATA_WIDTH-1:0] mem_q [DEPTH] = '{default: '0};
  logic [DATA_WIDTH-1:0] q_q = '0;
  logic [DATA_WIDTH-1:0] q_d;

  // Write-through: a write also presents the new word on the read register.
  always_comb begin
    q_d = mem_q[address];
    if (reset) begin
      q_d = '0;
    end else if (wren) begin
      q_d = data;
    end
  end

  always_ff @(posedge clock) begin
    q_q <= q_d;
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wren) begin
      mem_q[address] <= data;
    end
  end

  assign q = q_q;

endmodule

// File: tb/tb_data_memory_16x4.sv
// Self-checking bench for data_memory_16x4: directed vector table plus
// randomized traffic against an array-based reference model.
module tb_data_memory_16x4;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] address;
  logic [3:0] data;
  logic       wren;
  logic [3:0] q;

  int n_cmp = 0;
  int n_bad = 0;

  logic [3:0] model [16];

  typedef struct {
    logic       rst;
    logic       wr;
    logic [3:0] addr;
    logic [3:0] din;
    logic [3:0] exp_q;
    string      name;
  } vec_t;

  vec_t vecs [$];

  data_memory_16x4 dut (
    .clock   (clock),
    .reset   (reset),
    .address (address),
    .data    (data),
    .wren    (wren),
    .q       (q)
  );

  always #5 clock = ~clock;

  // Apply one transaction at the next rising edge; keep the model in step.
  task automatic step(input logic rst, input logic wr, input logic [3:0] a,
                      input logic [3:0] d, output logic [3:0] model_q);
    reset   = rst;
    wren    = wr;
    address = a;
    data    = d;
    @(posedge clock);
    #1;
    if (rst) begin
      foreach (model[i]) model[i] = 4'h0;
      model_q = 4'h0;
    end else if (wr) begin
      model[a] = d;
      model_q  = d;
    end else begin
      model_q = model[a];
    end
  endtask

  task automatic check(input string name, input logic [3:0] got, input logic [3:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: q=%h expected=%h at t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic add(input logic rst, input logic wr, input logic [3:0] a,
                     input logic [3:0] d, input logic [3:0] e, input string nm);
    vec_t v;
    v.rst = rst; v.wr = wr; v.addr = a; v.din = d; v.exp_q = e; v.name = nm;
    vecs.push_back(v);
  endtask

  initial begin
    logic [3:0] mq;
    logic       r, w;
    logic [3:0] a, d;

    reset = 1'b0; wren = 1'b0; address = 4'h0; data = 4'h0;
    foreach (model[i]) model[i] = 4'h0;

    for (int i = 0; i < 16; i++) add(0, 0, 4'(i), 4'h0, 4'h0, "powerup_read");
    add(0, 0, 4'h0, 4'hA, 4'h0, "write_blocked");
    add(0, 0, 4'h0, 4'h0, 4'h0, "blocked_readback");
    add(0, 1, 4'h0, 4'hA, 4'hA, "wt_0");
    add(0, 1, 4'h1, 4'hB, 4'hB, "wt_1");
    add(0, 1, 4'h5, 4'hF, 4'hF, "wt_5");
    add(0, 0, 4'h0, 4'h0, 4'hA, "rd_0");
    add(0, 0, 4'h1, 4'h0, 4'hB, "rd_1");
    add(0, 0, 4'h5, 4'h0, 4'hF, "rd_5");
    add(0, 0, 4'h2, 4'h0, 4'h0, "rd_2_empty");
    add(1, 1, 4'h3, 4'h7, 4'h0, "reset_blocks_write");
    add(0, 0, 4'h0, 4'h0, 4'h0, "post_rst_0");
    add(0, 0, 4'h1, 4'h0, 4'h0, "post_rst_1");
    add(0, 0, 4'h3, 4'h0, 4'h0, "post_rst_3");
    add(0, 0, 4'h5, 4'h0, 4'h0, "post_rst_5");
    add(0, 1, 4'h0, 4'hA, 4'hA, "ow_first");
    add(0, 1, 4'h0, 4'h3, 4'h3, "ow_second");
    add(0, 0, 4'h0, 4'h0, 4'h3, "ow_read");
    add(0, 1, 4'h4, 4'h9, 4'h9, "pre_hold_write");
    add(1, 1, 4'h4, 4'h6, 4'h0, "rst_hold_1");
    add(1, 1, 4'h4, 4'h6, 4'h0, "rst_hold_2");
    add(0, 0, 4'h4, 4'h0, 4'h0, "after_hold_read");
    add(0, 1, 4'h4, 4'hC, 4'hC, "resume_write");
    add(0, 0, 4'h4, 4'h5, 4'hC, "resume_read");

    #2;
    check("powerup_q", q, 4'h0);

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].wr, vecs[i].addr, vecs[i].din, mq);
      check(vecs[i].name, q, vecs[i].exp_q);
    end

    // q must hold between edges even if inputs wiggle mid-cycle.
    step(0, 0, 4'h4, 4'h0, mq);
    address = 4'hF; data = 4'h1; wren = 1'b1;
    #3;
    check("hold_between_edges", q, 4'hC);

    for (int n = 0; n < 400; n++) begin
      r = ($urandom_range(0, 31) == 0);
      w = $urandom_range(0, 1) == 1;
      a = 4'($urandom_range(0, 15));
      d = 4'($urandom_range(0, 15));
      step(r, w, a, d, mq);
      check("random", q, mq);
    end

    reset = 1'b0; wren = 1'b0;
    for (int i = 0; i < 16; i++) begin
      step(0, 0, 4'(i), 4'h0, mq);
      check("final_sweep", q, mq);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/data_memory_16x4.md
# data_memory_16x4

Single-port synchronous data RAM for the micro datapath: 16 words × 4 bits, one shared read/write address, write-enable gated writes, registered read output. It holds working data for the processor core. It is clocked by the data-memory clock, which runs at twice the core counter rate. Write-through semantics make the written word visible on `q` after the writing edge.

## Interface
- `DATA_WIDTH`, default 4: word width in bits.
- `ADDR_WIDTH`, default 4: address width in bits; depth = 2**ADDR_WIDTH (16).

Ports:
- `clock`  in  1: sole clock; all state changes on its rising edge.
- `reset`  in  1: synchronous, active-high reset, sampled on the `clock` rising edge.
- `address`  in  ADDR_WIDTH: word address for both read and write.
- `data`  in  DATA_WIDTH: write data.
- `wren`  in  1: write enable, active-high.
- `q`  out  DATA_WIDTH: registered read data.

## Operation
- Storage: array of 2**ADDR_WIDTH words × DATA_WIDTH bits. All words and `q` are 0 at power-up (initialised), so the memory reads empty before any write or reset.
- Every rising edge of `clock`, evaluated in this priority:
  1. `reset`=1: all words cleared to 0 and `q` <= 0. Any concurrent write is discarded.
  2. `wren`=1: mem[`address`] <= `data`, and `q` <= `data` (write-through / new-data read-during-write).
  3. `wren`=0: mem unchanged; `q` <= mem[`address`].
- `data` is ignored when `wren`=0; no location changes.
- Address space is fully decoded; no out-of-range addresses exist and there is no wrap logic.
- Consecutive writes to different addresses each update only their own word.
- Same-address write followed by a read returns the written value.
- No handshake: every cycle is a complete, independent transaction.
- No X propagation on `q` after power-up or reset.

## Timing
- Read latency: 1 clock. `q` reflects the `address` sampled at the most recent rising edge. `q` is held stable between edges.
- Write latency: 1 clock. The word is committed at the edge where `wren`=1, and `q` shows the new `data` from that same edge.
- Read of a just-written location on the next edge returns the new value; there is no stale-data window.
- Inputs must meet setup before the rising edge. Input changes between edges have no effect until the next edge.
- Reset takes effect at the first rising edge with `reset`=1; `q`=0 from that edge.
  - While `reset` is held, `q` stays 0 and all writes are blocked.
  - On the first edge after `reset` deasserts, normal operation resumes.
- Reset asserted mid-sequence (after writes) destroys all stored contents; subsequent reads return 0 until rewritten.

## Test plan
- Power-up read: `address`=0, `wren`=0, one edge -> `q`=0x0; sweep addresses 0..15 -> all read 0x0.
- Write blocked: `address`=0, `data`=0xA, `wren`=0, one edge -> `q`=0x0; then read address 0 -> 0x0.
- Write-through: write 0xA@0, then 0xB@1, then 0xF@5, one edge each with `wren`=1 -> after each edge `q` equals the written value (0xA, 0xB, 0xF).
- Readback: `wren`=0, `data`=0; `address` 0, 1, 5 on successive edges -> `q` = 0xA, 0xB, 0xF; address 2 -> 0x0.
- Reset: after the writes above, assert `reset` for one edge with `wren`=1, `address`=3, `data`=0x7 -> `q`=0x0. Then read addresses 0, 1, 3, 5 -> all 0x0.
- Overwrite: write 0xA@0, then 0x3@0, then read address 0 -> `q`=0x3.
